// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment display blocks.
package display_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_e;
endpackage

// File: rtl/display_7seg.sv
// BCD to active-low 7-segment decoder; segments a..g on bits 6..0.
module display_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = 7'b0000001;
            4'd1:    seg_o = 7'b1001111;
            4'd2:    seg_o = 7'b0010010;
            4'd3:    seg_o = 7'b0000110;
            4'd4:    seg_o = 7'b1001100;
            4'd5:    seg_o = 7'b0100100;
            4'd6:    seg_o = 7'b0100000;
            4'd7:    seg_o = 7'b0001111;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0000100;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with dead-time blanking,
// leading-zero suppression and frame-aligned double-buffered value updates.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  pending,
    output logic                  frame_done
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [TW-1:0]              tick_q, tick_d;
    logic [IW-1:0]              idx_q, idx_d;
    scan_state_e                state_q, state_d;
    logic [N_DIGITS-1:0][3:0]   stage_q, stage_d, disp_q, disp_d;
    logic                       pending_q, pending_d;
    logic                       fd_q, fd_d;
    logic [N_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                 seg_q, seg_d;

    logic                       slot_end, frame_end;
    logic [3:0]                 nibble, dec_in;
    logic [6:0]                 dec_seg;
    logic [N_DIGITS-1:0]        zero_above;

    assign slot_end  = (tick_q == TW'(TICK_DIV - 1));
    assign frame_end = slot_end && (idx_q == IW'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= SCAN_BLANK;
        else     state_q <= state_d;
    end

    always_comb begin
        tick_d = slot_end ? '0 : tick_q + TW'(1);
        idx_d  = idx_q;
        if (slot_end) idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        state_d = (tick_d < TW'(BLANK_CYCLES)) ? SCAN_BLANK : SCAN_DRIVE;

        // The boundary transfer reads the pre-edge stage; a coincident load
        // refills stage and keeps pending set for the next frame.
        stage_d   = stage_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (frame_end && pending_q) begin
            disp_d    = stage_q;
            pending_d = 1'b0;
        end
        if (load) begin
            stage_d   = value;
            pending_d = 1'b1;
        end
        fd_d = frame_end;
    end

    always_comb begin
        zero_above = '0;
        zero_above[N_DIGITS-1] = (disp_q[N_DIGITS-1] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && (disp_q[i] == 4'd0);
    end

    assign nibble = disp_q[idx_q];
    assign dec_in = (nibble <= BCD_MAX) ? nibble : 4'd0;

    display_7seg u_dec (
        .bcd_i (dec_in),
        .seg_o (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (state_q == SCAN_DRIVE) begin
            an_d[idx_q] = 1'b0;
            if (nibble > BCD_MAX)
                seg_d = SEG_BLANK;
            else if (blank_lz && (idx_q != '0) && zero_above[idx_q])
                seg_d = SEG_BLANK;
            else
                seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            idx_q     <= '0;
            stage_q   <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            fd_q      <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            fd_q      <= fd_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = fd_q;
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It holds a BCD value and walks one digit enable at a time through a single shared BCD-to-segment decoder. Between digits it inserts a dead-time blank to suppress ghosting. Value updates are double-buffered and applied only at a frame boundary, so the display never shows a torn number. It sits between the BCD producers (counters, measurement logic) and the board segment/anode pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned; digit 0 is least significant.
- `TICK_DIV`, 50000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 16: dead-time cycles at the start of each slot; must be ≥ 1.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: one-cycle strobe that captures `value` into the staging register.
- `value` in 4*N_DIGITS: packed BCD; nibble i (`value[4i+3:4i]`) is digit i.
- `blank_lz` in 1: when 1, enables leading-zero blanking.
- `seg` out 7: segments a..g on bits 6..0; active low; registered.
- `an` out N_DIGITS: digit enables; active low; at most one bit low; registered.
- `pending` out 1: staging holds a value not yet displayed.
- `frame_done` out 1: one-cycle pulse at the end of the last digit's slot.

## Operation
- Registers:
  - `tick`: slot cycle counter, 0..TICK_DIV-1.
  - `idx`: current digit, 0..N_DIGITS-1.
  - `state`: SCAN_BLANK or SCAN_DRIVE.
  - `stage` and `disp`: 4*N_DIGITS each.
  - `pending`.
- Slot sequencing:
  - `tick` increments every cycle.
  - At `tick`=TICK_DIV-1 it wraps to 0 and `idx` advances modulo N_DIGITS.
  - `state` is SCAN_BLANK while `tick` < BLANK_CYCLES, otherwise SCAN_DRIVE.
- SCAN_BLANK: next `an` = all ones; next `seg` = 7'h7F.
- SCAN_DRIVE: next `an` has only bit `idx` low; next `seg` = decoder output for `disp` nibble `idx`, with these overrides:
  - nibble > 9 → 7'h7F (the decoder is never given an out-of-range code).
  - `blank_lz`=1, `idx`>0, and nibbles `idx`..N_DIGITS-1 are all zero → 7'h7F.
  - Digit 0 is never blanked by the leading-zero rule.
- Load:
  - `load`=1 → `stage`<=`value`, `pending`<=1.
  - `load` while `pending`=1 overwrites `stage`; last write wins.
- Frame boundary (`idx`=N_DIGITS-1 and `tick`=TICK_DIV-1):
  - `frame_done` pulses.
  - If `pending`=1, `disp`<=`stage` and `pending`<=0.
- Load on the boundary cycle: the transfer uses the pre-edge `stage`. The new `value` lands in `stage` and `pending` stays 1, so it is applied at the next boundary.
- Reset values:
  - `tick`=0, `idx`=0, `state`=SCAN_BLANK.
  - `stage`=0, `disp`=0, `pending`=0, `frame_done`=0.
  - `an`=all ones, `seg`=7'h7F.
- Reset mid-frame aborts the scan immediately. Any staged value is discarded.

## Timing
- Frame length: N_DIGITS*TICK_DIV cycles. `frame_done` period is identical.
- `seg`/`an` lag the internal `tick`/`idx`/`state` by exactly one cycle (registered outputs).
- Dead time: all anodes high for BLANK_CYCLES cycles before every digit, including the first digit after reset.
- `load` → display latency: up to one frame plus one cycle. It is exactly one output cycle after the boundary at which the transfer occurs.
- `pending` rises the cycle after `load` and falls the cycle after the transfer.
- `seg` and `an` change on the same edge; no output glitching, since both are register outputs.

## Structure
- Shared package `display_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - Scan state enum {SCAN_BLANK, SCAN_DRIVE}.
  - `BCD_MAX` = 4'd9.
- One sub-module: a single instance of the team's `display_7seg` decoder (4-bit in, 7-bit active-low out), shared across all digits by the `idx` mux.
- Counter widths: `$clog2(TICK_DIV)` and `$clog2(N_DIGITS)`; minimum 1 bit.

## Test plan
All scenarios use N_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
- **Reset:** assert `rst` 3 cycles → `an`=4'b1111, `seg`=7'h7F, `pending`=0. First `an`=4'b1110 appears 3 cycles after release.
- **Load/scan:** `load` with `value`=16'h1234 mid-frame → `pending`=1 until the boundary. The next frame drives, in order:
  - `an` 1110 with `seg` 7'b1001100 (4)
  - `an` 1101 with `seg` 7'b0000110 (3)
  - `an` 1011 with `seg` 7'b0010010 (2)
  - `an` 0111 with `seg` 7'b1001111 (1)
  - each digit is preceded by 2 cycles of `an`=1111.
- **Leading-zero blanking:** `value`=16'h0070, `blank_lz`=1 → digit 0 shows 0 (7'b0000001), digit 1 shows 7, digits 2–3 show 7'h7F with their anodes still enabled. With `blank_lz`=0, digits 2–3 show 0.
- **Invalid BCD:** `value`=16'h00A5 → digit 1 shows 7'h7F; digit 0 shows 5 (7'b0100100).
- **Load collisions:**
  - `load` 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed.
  - `load` exactly on the boundary cycle → the old staged value is displayed, `pending` stays 1, and the new value appears one frame later.
- **Reset mid-frame:** `rst` during the digit-2 slot with `pending`=1 → outputs are blanked next cycle, `disp`=0, `pending`=0, and scanning restarts at digit 0.
